uart_tx_frame_gen: RTL and testbench

- Standalone UART transmit framer with its own bit-rate divider.
- Serialises one byte per valid/ready handshake onto a TXD line: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between the APB/stream write path and the pad.
- Pairs with the team's UART receive path: same frame encodings and same divider meaning.

---
 rtl/uart_tx_frame_gen_if.sv | 11 +
 rtl/uart_tx_frame_gen.sv | 121 ++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_gen_if.sv
// rtl/uart_tx_frame_gen_if.sv - byte write handshake between the stream/APB write path and the UART framer
interface uart_tx_frame_gen_if #(
  parameter int DATA_MAX = 8
);
  logic                valid;
  logic                ready;
  logic [DATA_MAX-1:0] payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - UART transmit framer: start, 5-8 data bits LSB first, optional parity, 1/2 stop bits
module uart_tx_frame_gen #(
  parameter int DIV_WIDTH = 20,
  parameter int DATA_MAX  = 8
) (
  input  logic                 io_mainClk,
  input  logic                 resetCtrl_systemReset_n,
  input  logic [2:0]           io_config_frame_dataLength,
  input  logic                 io_config_frame_stop,
  input  logic [1:0]           io_config_frame_parity,
  input  logic [DIV_WIDTH-1:0] io_config_clockDivider,
  uart_tx_frame_gen_if.slave   io_write,
  input  logic                 io_cts,
  input  logic                 io_break,
  output logic                 io_txd,
  output logic                 io_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] bit_cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DATA_MAX-1:0]  shift_q;
  logic [2:0]           len_q;
  logic [2:0]           bit_idx;
  logic                 par_en_q;
  logic                 par_odd_q;
  logic                 stop2_q;
  logic                 stop_second;
  logic                 par_acc;

  assign io_write.ready = (state == IDLE) && !io_cts && !io_break;

  // txd is registered: each bit-end edge loads the value of the bit that starts next
  always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset_n) begin
    if (!resetCtrl_systemReset_n) begin
      state       <= IDLE;
      io_txd      <= 1'b1;
      io_busy     <= 1'b0;
      bit_cnt     <= '0;
      div_q       <= '0;
      shift_q     <= '0;
      len_q       <= '0;
      bit_idx     <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_second <= 1'b0;
      par_acc     <= 1'b0;
    end else if (state == IDLE) begin
      io_txd <= !io_break;
      if (io_write.valid && io_write.ready) begin
        shift_q     <= io_write.payload;
        len_q       <= io_config_frame_dataLength;
        par_en_q    <= io_config_frame_parity[1];
        par_odd_q   <= io_config_frame_parity[0];
        stop2_q     <= io_config_frame_stop;
        div_q       <= io_config_clockDivider;
        bit_cnt     <= io_config_clockDivider;
        bit_idx     <= '0;
        par_acc     <= 1'b0;
        stop_second <= 1'b0;
        io_txd      <= 1'b0;
        io_busy     <= 1'b1;
        state       <= START;
      end
    end else if (bit_cnt != '0) begin
      bit_cnt <= bit_cnt - DIV_WIDTH'(1);
    end else begin
      bit_cnt <= div_q;
      case (state)
        START: begin
          io_txd <= shift_q[0];
          state  <= DATA;
        end
        DATA: begin
          par_acc <= par_acc ^ shift_q[0];
          shift_q <= shift_q >> 1;
          if (bit_idx == len_q) begin
            if (par_en_q) begin
              io_txd <= par_acc ^ shift_q[0] ^ par_odd_q;
              state  <= PARITY;
            end else begin
              io_txd <= 1'b1;
              state  <= STOP;
            end
          end else begin
            bit_idx <= bit_idx + 3'd1;
            io_txd  <= shift_q[1];
          end
        end
        PARITY: begin
          io_txd <= 1'b1;
          state  <= STOP;
        end
        STOP: begin
          if (stop2_q && !stop_second) begin
            stop_second <= 1'b1;
          end else begin
            io_txd  <= !io_break;
            io_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          io_txd  <= 1'b1;
          io_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// tb/tb_uart_tx_frame_gen.sv - directed, table-driven bench for uart_tx_frame_gen
module tb_uart_tx_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cfg_len = 3'd7;
  logic        cfg_stop = 1'b0;
  logic [1:0]  cfg_par = 2'b00;
  logic [19:0] cfg_div = 20'd0;
  logic        cts = 1'b0;
  logic        brk = 1'b0;
  logic        txd;
  logic        busy;

  int passed = 0;
  int total  = 0;

  uart_tx_frame_gen_if #(.DATA_MAX(8)) wr ();

  uart_tx_frame_gen #(.DIV_WIDTH(20), .DATA_MAX(8)) dut (
    .io_mainClk                 (clk),
    .resetCtrl_systemReset_n    (rst_n),
    .io_config_frame_dataLength (cfg_len),
    .io_config_frame_stop       (cfg_stop),
    .io_config_frame_parity     (cfg_par),
    .io_config_clockDivider     (cfg_div),
    .io_write                   (wr),
    .io_cts                     (cts),
    .io_break                   (brk),
    .io_txd                     (txd),
    .io_busy                    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          div;
    logic [2:0]  len;
    logic        stop;
    logic [1:0]  par;
    logic [7:0]  payload;
    int          nbits;
    logic [15:0] bits;
  } rec_t;

  rec_t tbl[9];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic wait_ready(output int waited);
    waited = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      waited++;
      if (wr.ready) break;
    end
    check("ready_seen", int'(wr.ready), 1);
  endtask

  // action 1: change divider/parity, 2: raise cts, 3: raise break -- applied at sample act_k
  task automatic run_frame(input string name, input rec_t r, input int action, input int act_k);
    int w;
    int bad_txd;
    int bad_busy;
    int nclk;
    cfg_div  = 20'(r.div);
    cfg_len  = r.len;
    cfg_stop = r.stop;
    cfg_par  = r.par;
    wr.payload = r.payload;
    wr.valid = 1'b1;
    wait_ready(w);
    @(posedge clk);
    #1 wr.valid = 1'b0;
    bad_txd = 0;
    bad_busy = 0;
    nclk = (r.div + 1) * r.nbits;
    for (int k = 0; k < nclk; k++) begin
      @(negedge clk);
      if (txd !== r.bits[k / (r.div + 1)]) bad_txd++;
      if (busy !== 1'b1) bad_busy++;
      if (k == act_k) begin
        if (action == 1) begin
          cfg_div = 20'd9;
          cfg_par = 2'b11;
        end else if (action == 2) begin
          cts = 1'b1;
        end else if (action == 3) begin
          brk = 1'b1;
        end
      end
    end
    check({name, "_txd_errs"}, bad_txd, 0);
    check({name, "_busy_errs"}, bad_busy, 0);
    @(negedge clk);
    check({name, "_busy_end"}, int'(busy), 0);
    check({name, "_txd_end"}, int'(txd), int'(!brk));
    check({name, "_ready_end"}, int'(wr.ready), int'(!(cts || brk)));
  endtask

  logic [7:0]  b2b_data [3];
  logic [15:0] b2b_bits [3];

  initial begin
    int w;
    int bad;

    //              div len   stop  par    payload nbits bits
    tbl[0] = '{3, 3'd7, 1'b0, 2'b00, 8'h55, 10, 16'h02AA};
    tbl[1] = '{0, 3'd6, 1'b1, 2'b10, 8'h41, 11, 16'h0682};
    tbl[2] = '{0, 3'd6, 1'b1, 2'b11, 8'h41, 11, 16'h0782};
    tbl[3] = '{0, 3'd6, 1'b1, 2'b11, 8'hC1, 11, 16'h0782};
    tbl[4] = '{1, 3'd4, 1'b0, 2'b10, 8'h1D,  8, 16'h00BA};
    tbl[5] = '{2, 3'd7, 1'b1, 2'b11, 8'hFF, 12, 16'h0FFE};
    tbl[6] = '{0, 3'd5, 1'b0, 2'b01, 8'h2A,  8, 16'h00D4};
    tbl[7] = '{3, 3'd7, 1'b0, 2'b10, 8'h55, 11, 16'h04AA};
    tbl[8] = '{9, 3'd7, 1'b0, 2'b11, 8'h55, 11, 16'h06AA};

    b2b_data[0] = 8'hA5; b2b_bits[0] = 16'h034A;
    b2b_data[1] = 8'h3C; b2b_bits[1] = 16'h0278;
    b2b_data[2] = 8'hFF; b2b_bits[2] = 16'h03FE;

    wr.valid = 1'b0;
    wr.payload = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", int'(txd), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(wr.ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_frame($sformatf("vec%0d", i), tbl[i], (i == 7) ? 1 : 0, 10);

    // cts with valid: nothing leaves
    cts = 1'b1;
    wr.valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1 || wr.ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("cts_hold_errs", bad, 0);
    wr.valid = 1'b0;
    cts = 1'b0;

    // cts raised mid-frame: frame completes, next one waits for cts release
    run_frame("cts_mid", tbl[1], 2, 3);
    wr.payload = 8'h55;
    wr.valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("cts_after_errs", bad, 0);
    cts = 1'b0;
    @(posedge clk);
    #1 wr.valid = 1'b0;
    @(negedge clk);
    check("cts_release_busy", int'(busy), 1);
    check("cts_release_txd", int'(txd), 0);
    for (int t = 0; t < 200 && busy; t++) @(negedge clk);
    check("cts_release_done", int'(busy), 0);
    repeat (2) @(negedge clk);

    // break in idle for 50 clocks
    brk = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 1'b0 || wr.ready !== 1'b0) bad++;
    end
    check("brk_idle_errs", bad, 0);
    brk = 1'b0;
    @(negedge clk);
    check("brk_rel_txd", int'(txd), 1);
    check("brk_rel_ready", int'(wr.ready), 1);

    // break raised mid-frame: stop bits still go out, then line low
    run_frame("brk_mid", tbl[4], 3, 5);
    repeat (4) @(negedge clk);
    check("brk_mid_hold", int'(txd), 0);
    brk = 1'b0;
    @(negedge clk);
    check("brk_mid_rel_txd", int'(txd), 1);

    // back-to-back frames, D=1, 8N1
    cfg_div = 20'd1;
    cfg_len = 3'd7;
    cfg_stop = 1'b0;
    cfg_par = 2'b00;
    wr.valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wr.payload = b2b_data[b];
      wait_ready(w);
      if (b > 0) begin
        check($sformatf("b2b_gap%0d", b), w, 1);
        check($sformatf("b2b_idle_txd%0d", b), int'(txd), 1);
      end
      @(posedge clk);
      #1;
      if (b == 2) wr.valid = 1'b0;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (txd !== b2b_bits[b][k / 2] || busy !== 1'b1) bad++;
      end
      check($sformatf("b2b_frame%0d_errs", b), bad, 0);
    end

    // reset in the middle of a frame
    @(negedge clk);
    wr.payload = 8'h3C;
    wr.valid = 1'b1;
    wait_ready(w);
    @(posedge clk);
    #1 wr.valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txd", int'(txd), 1);
    check("rst_mid_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_txd", int'(txd), 1);
    check("rst_rel_busy", int'(busy), 0);
    check("rst_rel_ready", int'(wr.ready), 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rst_no_retry_errs", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
